// File: rtl/composer_pkg.sv
// Shared definitions for the composer sequencing controller:
// state encoding, state type and port-width helpers.
package composer_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_MENU        = 4'd0;
    localparam state_t ST_START       = 4'd1;
    localparam state_t ST_SELECT_MODE = 4'd2;
    localparam state_t ST_SELECT_SONG = 4'd3;
    localparam state_t ST_DRAW_SCORE  = 4'd4;
    localparam state_t ST_EDIT        = 4'd5;
    localparam state_t ST_DELETE      = 4'd6;
    localparam state_t ST_INSERT      = 4'd7;
    localparam state_t ST_MAKE_SONG   = 4'd8;
    localparam state_t ST_PLAY        = 4'd9;
    localparam state_t ST_PLAY_WAIT   = 4'd10;

    // Width of a track index; a single track still needs one bit.
    function automatic int trk_width(input int num_tracks);
        return (num_tracks > 1) ? $clog2(num_tracks) : 1;
    endfunction

    // Width of a note slot address within one track.
    function automatic int addr_width(input int max_notes);
        return (max_notes > 1) ? $clog2(max_notes) : 1;
    endfunction

endpackage

// File: rtl/composer_play_seq.sv
// Playback stepper: divides PLAY time into NOTE_TICKS-cycle steps and walks
// the slot address from 0 up to play_len-1, optionally looping.
module composer_play_seq #(
    parameter int NOTE_TICKS = 8,
    parameter int AW         = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic          loop_mode,
    input  logic [AW:0]   play_len,
    output logic          step_start,
    output logic [AW-1:0] addr,
    output logic          done
);

    localparam int TW = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;

    logic [TW-1:0] tick_r;
    logic [AW-1:0] addr_r;
    logic          empty_s;
    logic          last_tick_s;
    logic          last_step_s;

    // Step boundaries and end-of-pass detection from the tick/address registers.
    always_comb begin
        empty_s     = (play_len == {(AW + 1){1'b0}});
        last_tick_s = (tick_r == TW'(NOTE_TICKS - 1));
        last_step_s = (({1'b0, addr_r} + {{AW{1'b0}}, 1'b1}) == play_len);
        step_start  = run && !empty_s && (tick_r == {TW{1'b0}});
        done        = run && (empty_s || (last_tick_s && last_step_s && !loop_mode));
        addr        = addr_r;
    end

    // Tick counter and address stepping; both idle at zero outside PLAY.
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            tick_r <= {TW{1'b0}};
            addr_r <= {AW{1'b0}};
        end else if (empty_s) begin
            tick_r <= tick_r;
            addr_r <= addr_r;
        end else if (last_tick_s) begin
            tick_r <= {TW{1'b0}};
            if (last_step_s) begin
                addr_r <= {AW{1'b0}};
            end else begin
                addr_r <= addr_r + AW'(1);
            end
        end else begin
            tick_r <= tick_r + TW'(1);
        end
    end

endmodule

// File: rtl/composer_seq_ctrl.sv
// Composer main controller: menu/mode/edit/play FSM, per-track note counters,
// insert delay and playback sequencing. All outputs are registered decodes.
// Optional build macro COMPOSER_LOOP_EN adds the loop_mode input for looped
// playback (play acts as stop while looping).
module composer_seq_ctrl
    import composer_pkg::*;
#(
    parameter int  NUM_TRACKS   = 2,
    parameter int  MAX_NOTES    = 32,
    parameter int  INSERT_DELAY = 4,
    parameter int  NOTE_TICKS   = 8,
    localparam int TRK_W        = trk_width(NUM_TRACKS),
    localparam int AW           = addr_width(MAX_NOTES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             restart,
    input  logic             start,
    input  logic             make_my_own,
    input  logic             play_saved,
    input  logic             score_drawn,
    input  logic             play,
    input  logic             play_again,
    input  logic             end_insert,
    input  logic             insert,
    input  logic             delete,
    input  logic [TRK_W-1:0] track_sel,
`ifdef COMPOSER_LOOP_EN
    input  logic             loop_mode,
`endif
    output logic             menu_enable,
    output logic             list_enable,
    output logic             song_list_enable,
    output logic             draw_score,
    output logic             end_vga_display,
    output logic             note_we,
    output logic             note_del,
    output logic [TRK_W-1:0] wr_track,
    output logic [AW-1:0]    wr_addr,
    output logic             is_full,
    output logic             play_enable,
    output logic             note_strobe,
    output logic [AW-1:0]    play_addr,
    output logic [3:0]       state_o
);

    localparam int              CW     = AW + 1;
    localparam int              IW     = (INSERT_DELAY > 1) ? $clog2(INSERT_DELAY) : 1;
    localparam logic [CW-1:0]   FULL_C = CW'(MAX_NOTES);

    state_t          state_r;
    state_t          state_n_s;
    logic [CW-1:0]   cnt_r [NUM_TRACKS];
    logic [CW-1:0]   cnt_sel_s;
    logic [CW-1:0]   del_addr_s;
    logic [CW-1:0]   max_cnt_s;
    logic [CW-1:0]   play_len_r;
    logic [IW-1:0]   ins_tmr_r;
    logic            trk_ok_s;
    logic            is_full_s;
    logic            ins_last_s;
    logic            ins_wr_s;
    logic            del_s;
    logic            loop_s;
    logic            seq_run_s;
    logic            seq_step_s;
    logic            seq_done_s;
    logic [AW-1:0]   seq_addr_s;

    // Selected-track count, edit strobes and longest track for playback length.
    always_comb begin
        trk_ok_s = (int'(track_sel) < NUM_TRACKS);
        if (trk_ok_s) begin
            cnt_sel_s = cnt_r[track_sel];
        end else begin
            cnt_sel_s = {CW{1'b0}};
        end
        del_addr_s = cnt_sel_s - CW'(1);
        is_full_s  = trk_ok_s && (cnt_sel_s == FULL_C);
        ins_last_s = (ins_tmr_r == IW'(INSERT_DELAY - 1));
        ins_wr_s   = (state_r == ST_INSERT) && (ins_tmr_r == {IW{1'b0}}) && trk_ok_s && !is_full_s;
        del_s      = (state_r == ST_DELETE) && trk_ok_s && (cnt_sel_s != {CW{1'b0}});
        max_cnt_s  = {CW{1'b0}};
        for (int t = 0; t < NUM_TRACKS; t++) begin
            if (cnt_r[t] > max_cnt_s) begin
                max_cnt_s = cnt_r[t];
            end else begin
                max_cnt_s = max_cnt_s;
            end
        end
`ifdef COMPOSER_LOOP_EN
        loop_s = loop_mode;
`else
        loop_s = 1'b0;
`endif
        seq_run_s = (state_r == ST_PLAY) && !restart;
    end

    composer_play_seq #(
        .NOTE_TICKS (NOTE_TICKS),
        .AW         (AW)
    ) u_play_seq (
        .clk        (clk),
        .reset      (reset),
        .run        (seq_run_s),
        .loop_mode  (loop_s),
        .play_len   (play_len_r),
        .step_start (seq_step_s),
        .addr       (seq_addr_s),
        .done       (seq_done_s)
    );

    // Next-state decision for the controller FSM (restart is applied in the register).
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            ST_MENU:        if (start) state_n_s = ST_START; else state_n_s = ST_MENU;
            ST_START:       state_n_s = ST_SELECT_MODE;
            ST_SELECT_MODE: begin
                if (make_my_own) begin
                    state_n_s = ST_DRAW_SCORE;
                end else if (play_saved) begin
                    state_n_s = ST_SELECT_SONG;
                end else begin
                    state_n_s = ST_SELECT_MODE;
                end
            end
            ST_SELECT_SONG: if (play) state_n_s = ST_PLAY; else state_n_s = ST_SELECT_SONG;
            ST_DRAW_SCORE:  if (score_drawn) state_n_s = ST_EDIT; else state_n_s = ST_DRAW_SCORE;
            ST_EDIT: begin
                if (delete) begin
                    state_n_s = ST_DELETE;
                end else if (end_insert || is_full_s) begin
                    state_n_s = ST_MAKE_SONG;
                end else if (insert) begin
                    state_n_s = ST_INSERT;
                end else begin
                    state_n_s = ST_EDIT;
                end
            end
            ST_DELETE:      state_n_s = ST_EDIT;
            ST_INSERT:      if (ins_last_s) state_n_s = ST_EDIT; else state_n_s = ST_INSERT;
            ST_MAKE_SONG:   if (play) state_n_s = ST_PLAY; else state_n_s = ST_MAKE_SONG;
            ST_PLAY: begin
                if (seq_done_s) begin
                    state_n_s = ST_PLAY_WAIT;
`ifdef COMPOSER_LOOP_EN
                end else if (play) begin
                    state_n_s = ST_PLAY_WAIT;
`endif
                end else begin
                    state_n_s = ST_PLAY;
                end
            end
            ST_PLAY_WAIT:   if (play_again) state_n_s = ST_PLAY; else state_n_s = ST_PLAY_WAIT;
            default:        state_n_s = ST_MENU;
        endcase
    end

    // State register, insert dwell timer and latched playback length.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_MENU;
            ins_tmr_r  <= {IW{1'b0}};
            play_len_r <= {CW{1'b0}};
        end else if (restart) begin
            state_r    <= ST_START;
            ins_tmr_r  <= {IW{1'b0}};
        end else begin
            state_r <= state_n_s;
            if ((state_r == ST_INSERT) && !ins_last_s) begin
                ins_tmr_r <= ins_tmr_r + IW'(1);
            end else begin
                ins_tmr_r <= {IW{1'b0}};
            end
            if ((state_r == ST_SELECT_SONG) && play) begin
                play_len_r <= FULL_C;
            end else if ((state_r == ST_MAKE_SONG) && play) begin
                play_len_r <= max_cnt_s;
            end
        end
    end

    // Per-track note counters: cleared when a new score is drawn, saturating edits.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int t = 0; t < NUM_TRACKS; t++) begin
                cnt_r[t] <= {CW{1'b0}};
            end
        end else if (!restart) begin
            case (state_r)
                ST_DRAW_SCORE: begin
                    for (int t = 0; t < NUM_TRACKS; t++) begin
                        cnt_r[t] <= {CW{1'b0}};
                    end
                end
                ST_DELETE: if (del_s) cnt_r[track_sel] <= del_addr_s;
                ST_INSERT: if (ins_wr_s) cnt_r[track_sel] <= cnt_sel_s + CW'(1);
                default: ;
            endcase
        end
    end

    // Registered output decode; restart drops every enable and strobe at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            menu_enable      <= 1'b0;
            list_enable      <= 1'b0;
            song_list_enable <= 1'b0;
            draw_score       <= 1'b0;
            end_vga_display  <= 1'b0;
            note_we          <= 1'b0;
            note_del         <= 1'b0;
            wr_track         <= {TRK_W{1'b0}};
            wr_addr          <= {AW{1'b0}};
            is_full          <= 1'b0;
            play_enable      <= 1'b0;
            note_strobe      <= 1'b0;
            play_addr        <= {AW{1'b0}};
            state_o          <= ST_MENU;
        end else if (restart) begin
            menu_enable      <= 1'b0;
            list_enable      <= 1'b0;
            song_list_enable <= 1'b0;
            draw_score       <= 1'b0;
            end_vga_display  <= 1'b0;
            note_we          <= 1'b0;
            note_del         <= 1'b0;
            is_full          <= is_full_s;
            play_enable      <= 1'b0;
            note_strobe      <= 1'b0;
            play_addr        <= {AW{1'b0}};
            state_o          <= state_r;
        end else begin
            menu_enable      <= (state_r == ST_MENU);
            list_enable      <= (state_r == ST_START);
            song_list_enable <= (state_r == ST_SELECT_SONG);
            draw_score       <= (state_r == ST_DRAW_SCORE);
            end_vga_display  <= (state_r == ST_PLAY_WAIT);
            note_we          <= ins_wr_s;
            note_del         <= del_s;
            if (ins_wr_s) begin
                wr_track <= track_sel;
                wr_addr  <= cnt_sel_s[AW-1:0];
            end else if (del_s) begin
                wr_track <= track_sel;
                wr_addr  <= del_addr_s[AW-1:0];
            end
            is_full          <= is_full_s;
            play_enable      <= (state_r == ST_PLAY);
            note_strobe      <= seq_step_s;
            play_addr        <= seq_addr_s;
            state_o          <= state_r;
        end
    end

endmodule

// File: tb/tb_composer_seq_ctrl.sv
// Scoreboard bench for composer_seq_ctrl: randomized edits against a count
// model; expected note RAM strobes and playback steps are queued and checked
// by an independent monitor.
module tb_composer_seq_ctrl;

    localparam int NT  = 2;
    localparam int MN  = 32;
    localparam int ID  = 4;
    localparam int NTK = 8;

    localparam logic [3:0] S_MENU = 4'd0, S_START = 4'd1, S_SEL_MODE = 4'd2,
                           S_SEL_SONG = 4'd3, S_DRAW = 4'd4, S_EDIT = 4'd5,
                           S_DELETE = 4'd6, S_MAKE = 4'd8, S_PLAY = 4'd9, S_WAIT = 4'd10;

    localparam int P_RESTART = 0, P_START = 1, P_MINE = 2, P_SAVED = 3, P_DRAWN = 4,
                   P_PLAY = 5, P_AGAIN = 6, P_ENDINS = 7, P_INSERT = 8, P_DELETE = 9;

    localparam int K_WE = 0, K_DEL = 1, K_STROBE = 2;

    logic       clk = 1'b0, reset = 1'b1, restart = 1'b0, start = 1'b0;
    logic       make_my_own = 1'b0, play_saved = 1'b0, score_drawn = 1'b0, play = 1'b0;
    logic       play_again = 1'b0, end_insert = 1'b0, insert = 1'b0, delete = 1'b0;
    logic [0:0] track_sel = 1'b0;
    logic       loop_mode = 1'b0;
    logic       menu_enable, list_enable, song_list_enable, draw_score, end_vga_display;
    logic       note_we, note_del, is_full, play_enable, note_strobe;
    logic [0:0] wr_track;
    logic [4:0] wr_addr, play_addr;
    logic [3:0] state_o;

    typedef struct { int kind; int trk; int addr; } ev_t;
    ev_t exp_q[$];

    int total = 0, bad = 0, cyc = 0;
    int mcnt[NT];
    int last_we = -1, last_st = -1;

    composer_seq_ctrl dut (
        .clk(clk), .reset(reset), .restart(restart), .start(start),
        .make_my_own(make_my_own), .play_saved(play_saved), .score_drawn(score_drawn),
        .play(play), .play_again(play_again), .end_insert(end_insert),
        .insert(insert), .delete(delete), .track_sel(track_sel),
`ifdef COMPOSER_LOOP_EN
        .loop_mode(loop_mode),
`endif
        .menu_enable(menu_enable), .list_enable(list_enable),
        .song_list_enable(song_list_enable), .draw_score(draw_score),
        .end_vga_display(end_vga_display), .note_we(note_we), .note_del(note_del),
        .wr_track(wr_track), .wr_addr(wr_addr), .is_full(is_full),
        .play_enable(play_enable), .note_strobe(note_strobe),
        .play_addr(play_addr), .state_o(state_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every strobe the DUT presents must match the next queued expectation.
    always @(negedge clk) begin
        int k;
        ev_t e;
        if (note_we === 1'b1 || note_del === 1'b1 || note_strobe === 1'b1) begin
            k = (note_we === 1'b1) ? K_WE : ((note_del === 1'b1) ? K_DEL : K_STROBE);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: kind %0d at cycle %0d, none expected", k, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("event_kind", k, e.kind);
                if (k == K_STROBE) begin
                    chk("play_addr", int'(play_addr), e.addr);
                    if (e.addr != 0 && last_st >= 0) chk("strobe_gap", cyc - last_st, NTK);
                    last_st = cyc;
                end else begin
                    chk("wr_addr", int'(wr_addr), e.addr);
                    chk("wr_track", int'(wr_track), e.trk);
                    if (k == K_WE) begin
                        if (last_we >= 0) chk("we_spacing_ok", (cyc - last_we >= ID) ? 1 : 0, 1);
                        last_we = cyc;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sig(input int which, input logic v);
        case (which)
            P_RESTART: restart     = v;
            P_START:   start       = v;
            P_MINE:    make_my_own = v;
            P_SAVED:   play_saved  = v;
            P_DRAWN:   score_drawn = v;
            P_PLAY:    play        = v;
            P_AGAIN:   play_again  = v;
            P_ENDINS:  end_insert  = v;
            P_INSERT:  insert      = v;
            P_DELETE:  delete      = v;
            default:   ;
        endcase
    endtask

    task automatic pulse(input int which);
        set_sig(which, 1'b1);
        step();
        set_sig(which, 1'b0);
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, input string name);
        int n = 0;
        while (state_o !== s && n < budget) begin
            step();
            n++;
        end
        chk(name, int'(state_o), int'(s));
    endtask

    task automatic wait_q_empty(input int budget, input string name);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic do_insert(input int t);
        track_sel = t[0:0];
        if (mcnt[t] < MN) begin
            exp_q.push_back('{K_WE, t, mcnt[t]});
            mcnt[t]++;
        end
        pulse(P_INSERT);
        step();
        wait_state(S_EDIT, 20, "insert_return");
        chk("is_full", int'(is_full), (mcnt[t] == MN) ? 1 : 0);
    endtask

    task automatic do_delete(input int t);
        track_sel = t[0:0];
        if (mcnt[t] > 0) begin
            mcnt[t]--;
            exp_q.push_back('{K_DEL, t, mcnt[t]});
        end
        pulse(P_DELETE);
        step();
        chk("delete_state", int'(state_o), int'(S_DELETE));
        step();
        chk("delete_return", int'(state_o), int'(S_EDIT));
    endtask

    task automatic enter_edit();
        wait_state(S_SEL_MODE, 10, "reach_select_mode");
        pulse(P_MINE);
        wait_state(S_DRAW, 10, "reach_draw_score");
        chk("draw_score_on", int'(draw_score), 1);
        for (int t = 0; t < NT; t++) mcnt[t] = 0;
        pulse(P_DRAWN);
        wait_state(S_EDIT, 10, "reach_edit");
        chk("draw_score_off", int'(draw_score), 0);
    endtask

    task automatic push_pass(input int len);
        for (int a = 0; a < len; a++) exp_q.push_back('{K_STROBE, 0, a});
    endtask

    task automatic play_full(input int len, input int go);
        push_pass(len);
        pulse(go);
        step();
        chk("play_enable_on", int'(play_enable), 1);
        wait_state(S_WAIT, len * NTK + 10, "reach_play_wait");
        chk("end_vga_display", int'(end_vga_display), 1);
        chk("pass_drained", exp_q.size(), 0);
    endtask

    initial begin
        int mlen;
        for (int t = 0; t < NT; t++) mcnt[t] = 0;
        repeat (3) step();
        chk("rst_state", int'(state_o), int'(S_MENU));
        chk("rst_menu", int'(menu_enable), 0);
        chk("rst_play_addr", int'(play_addr), 0);
        chk("rst_is_full", int'(is_full), 0);
        reset = 1'b0;
        step();
        chk("menu_enable", int'(menu_enable), 1);

        pulse(P_START);
        wait_state(S_START, 5, "reach_start");
        chk("list_enable", int'(list_enable), 1);
        enter_edit();
        chk("cleared_is_full", int'(is_full), 0);

        // Directed edits: three notes on track 1, delete on empty and non-empty tracks.
        for (int i = 0; i < 3; i++) do_insert(1);
        do_delete(0);
        do_delete(1);

        // Randomized edit mix on both tracks.
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 2) == 2) do_delete(int'($urandom_range(0, NT - 1)));
            else do_insert(int'($urandom_range(0, NT - 1)));
        end

        // Fill track 0; a full track forces the exit from EDIT.
        while (mcnt[0] < MN) do_insert(0);
        wait_state(S_MAKE, 10, "full_to_make_song");
        chk("is_full_at_make", int'(is_full), 1);
        wait_q_empty(10, "edits_drained");

        mlen = 0;
        for (int t = 0; t < NT; t++) if (mcnt[t] > mlen) mlen = mcnt[t];
        play_full(mlen, P_PLAY);

        // play_again restarts at slot 0; restart after three steps aborts playback.
        push_pass(3);
        pulse(P_AGAIN);
        wait_q_empty(40, "replay_steps");
        pulse(P_RESTART);
        chk("restart_play_enable", int'(play_enable), 0);
        chk("restart_strobe", int'(note_strobe), 0);
        chk("restart_play_addr", int'(play_addr), 0);
        step();
        chk("restart_state", int'(state_o), int'(S_START));
        chk("restart_list_enable", int'(list_enable), 1);

        // Saved-song path always plays MAX_NOTES slots.
        wait_state(S_SEL_MODE, 10, "saved_select_mode");
        pulse(P_SAVED);
        wait_state(S_SEL_SONG, 10, "reach_select_song");
        chk("song_list_enable", int'(song_list_enable), 1);
        play_full(MN, P_PLAY);

        // Empty song: one PLAY cycle, no strobes.
        pulse(P_RESTART);
        enter_edit();
        pulse(P_ENDINS);
        wait_state(S_MAKE, 10, "empty_make_song");
        pulse(P_PLAY);
        step();
        chk("empty_play_state", int'(state_o), int'(S_PLAY));
        chk("empty_play_enable", int'(play_enable), 1);
        step();
        chk("empty_play_wait", int'(state_o), int'(S_WAIT));

`ifdef COMPOSER_LOOP_EN
        // Looping over a two-note song, then stopping at the end of a pass.
        pulse(P_RESTART);
        enter_edit();
        do_insert(0);
        do_insert(0);
        pulse(P_ENDINS);
        wait_state(S_MAKE, 10, "loop_make_song");
        loop_mode = 1'b1;
        for (int p = 0; p < 3; p++) push_pass(2);
        pulse(P_PLAY);
        wait_q_empty(80, "loop_passes");
        loop_mode = 1'b0;
        wait_state(S_WAIT, 30, "loop_stop");
`endif

        step();
        chk("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/composer_seq_ctrl.md
Name: composer_seq_ctrl

Overview:
- Next-generation main controller for the composer: a menu/mode/edit/play FSM plus the note-count, insert-delay and playback sequencing counters.
- Supports NUM_TRACKS independent tracks of up to MAX_NOTES notes each.
- Drives VGA screen enables, the note RAM write/delete strobes and the playback address.
- Sits between debounced user-input pulses and the datapath (note RAM, VGA drawer, audio).

Parameters:
NUM_TRACKS, 2, number of note tracks (1..8)
MAX_NOTES, 32, notes per track; counters saturate here
INSERT_DELAY, 4, cycles spent in INSERT before returning to EDIT (>=1)
NOTE_TICKS, 8, cycles per note step during playback (>=2)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
restart  in  1  return to START (pulse)
start, make_my_own, play_saved, score_drawn, play, play_again, end_insert  in  1 each  one-cycle user/datapath pulses
insert, delete  in  1 each  one-cycle edit pulses
track_sel  in  TRK_W=max(1,$clog2(NUM_TRACKS))  track being edited
menu_enable, list_enable, song_list_enable, draw_score, end_vga_display  out  1 each  screen enables
note_we  out  1  one-cycle write strobe to note RAM
note_del  out  1  one-cycle delete strobe
wr_track  out  TRK_W  track for note_we/note_del
wr_addr  out  AW=$clog2(MAX_NOTES)  slot for note_we/note_del
is_full  out  1  count[track_sel]==MAX_NOTES
play_enable  out  1  high throughout PLAY
note_strobe  out  1  one-cycle pulse at start of each note step
play_addr  out  AW  current playback slot
state_o  out  4  current state, debug

Behaviour:
- Reset: state MENU; all outputs 0; all counters 0.
- Priority per cycle: reset > restart (state<=START) > normal transition.
- States and transitions:
  - MENU -(start)-> START.
  - START -> SELECT_MODE (unconditional).
  - SELECT_MODE -(make_my_own)-> DRAW_SCORE; else -(play_saved)-> SELECT_SONG.
  - SELECT_SONG -(play)-> PLAY, with play_len=MAX_NOTES.
  - DRAW_SCORE -(score_drawn)-> EDIT. Entering DRAW_SCORE clears all track counters.
  - EDIT priority:
    - delete -> DELETE.
    - else end_insert or is_full -> MAKE_SONG.
    - else insert -> INSERT.
  - DELETE lasts exactly 1 cycle, then EDIT.
    - If count[track_sel]>0: note_del=1, wr_addr=count-1, count decrements.
    - If count==0: no strobe, no change.
  - INSERT:
    - First cycle: note_we=1, wr_addr=count[track_sel], wr_track=track_sel, count increments.
    - Stays INSERT_DELAY cycles total, then EDIT.
    - insert while already full is impossible (EDIT exits on is_full first).
  - MAKE_SONG -(play)-> PLAY, with play_len = max over tracks of count.
  - PLAY:
    - play_addr starts at 0; each step lasts NOTE_TICKS cycles.
    - note_strobe is high on the first cycle of each step.
    - After the step at play_len-1 completes -> PLAY_WAIT.
    - play_len==0 -> PLAY_WAIT after one cycle with no strobe.
  - PLAY_WAIT: end_vga_display=1. -(play_again)-> PLAY, restart from addr 0 with the same play_len.
- Screen enable decode:
  - menu_enable in MENU.
  - list_enable in START.
  - song_list_enable in SELECT_SONG.
  - draw_score in DRAW_SCORE.
  - play_enable in PLAY.
- Timing: all outputs are registered Moore decodes of current_state and counters, valid the cycle after the state register changes. Strobes are single-cycle even if input pulses are held.
- Width rules:
  - Counters are AW+1 bits and saturate at MAX_NOTES; they never wrap.
  - track_sel >= NUM_TRACKS is ignored: no strobe, no count change.
- restart mid-PLAY or mid-INSERT aborts immediately: strobes drop, counters retained, play_addr<=0.

Optional Feature:
- Macro: COMPOSER_LOOP_EN.
- Defined:
  - Adds input loop_mode (1 bit).
  - In PLAY with loop_mode=1, after the last step play_addr wraps to 0 and playback continues. PLAY_WAIT is entered only when loop_mode is 0 at the end of a pass, or on play (acts as stop).
- Undefined: no loop_mode port; playback always ends in PLAY_WAIT.

Decomposition:
- Package composer_pkg holds:
  - State encoding localparams (MENU=0 … PLAY_WAIT=10).
  - State typedef.
  - Helper function for TRK_W/AW.
- Sub-module composer_play_seq: tick counter plus play_addr stepping, with note_strobe/done output. Instantiated once.

Test Plan:
- Reset then start, make_my_own, score_drawn -> state EDIT; draw_score high exactly while in DRAW_SCORE; all counts 0.
- 3 insert pulses on track 1 (INSERT_DELAY=4) -> note_we at wr_addr 0,1,2; wr_track=1; count[1]=3; pulses 4 cycles apart minimum.
- delete with count 0 -> no note_del, return to EDIT after 1 cycle. delete with count 3 -> note_del at wr_addr 2, count 2.
- Fill track 0 to 32 -> is_full=1, EDIT->MAKE_SONG. play with counts {32,2} -> 32 note_strobes 8 cycles apart, play_addr 0..31, then PLAY_WAIT with end_vga_display=1.
- play_again in PLAY_WAIT -> play_addr restarts at 0. restart during PLAY -> START next cycle, play_enable low, list_enable high.
- COMPOSER_LOOP_EN, loop_mode=1, play_len=2 -> play_addr sequence 0,1,0,1…. Clear loop_mode -> PLAY_WAIT after the addr-1 step.
